// File: rtl/netlist_bist_if.sv
// netlist_bist_if: BIST <-> netlist/testbench bundle.
// master = BIST harness side, slave = netlist/environment side.
interface netlist_bist_if #(
  parameter int PAT_W = 16,
  parameter int RSP_W = 16
);
  logic             start_i;
  logic [PAT_W-1:0] pattern_o;
  logic             pattern_vld_o;
  logic [RSP_W-1:0] response_i;
  logic             busy_o;
  logic             done_o;
  logic [15:0]      signature_o;
  logic             pass_o;

  modport master (
    input  start_i, response_i,
    output pattern_o, pattern_vld_o, busy_o, done_o, signature_o, pass_o
  );

  modport slave (
    output start_i, response_i,
    input  pattern_o, pattern_vld_o, busy_o, done_o, signature_o, pass_o
  );
endinterface

// File: rtl/netlist_bist.sv
// netlist_bist: LFSR pattern source + MISR response compactor for
// gate-level netlist self-test. Optional golden compare is enabled with
// `NETLIST_BIST_COMPARE_EN; without it pass_o is tied low.
module netlist_bist #(
  parameter int          PAT_W   = 16,
  parameter int          RSP_W   = 16,
  parameter int          NUM_PAT = 256,
  parameter int          DUT_LAT = 0,
  parameter logic [15:0] SEED    = 16'h0001,
  parameter logic [15:0] GOLDEN  = 16'h0000
) (
  input  logic          CK,
  input  logic          RN,
  netlist_bist_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // Counter runs through RUN and FLUSH without reset in between, so FLUSH
  // ends at an absolute count; 17 bits covers NUM_PAT + DUT_LAT.
  localparam logic [16:0] RUN_END   = 17'(NUM_PAT - 1);
  localparam logic [16:0] FLUSH_END = 17'(NUM_PAT + DUT_LAT - 1);

  logic [1:0]  r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_misr;
  logic [16:0] r_cnt;
  logic        r_vld;

  logic        w_start;
  logic        w_cap_vld;
  logic        w_fb;
  logic [15:0] w_rsp;
  logic [15:0] w_misr_nxt;

  assign w_start    = bus.start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_rsp      = 16'(bus.response_i);
  assign w_misr_nxt = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h6801 : 16'h0000) ^ w_rsp;

  // Sequencer: pattern generation, counting and state transitions.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else if (w_start) begin
      r_state <= S_RUN;
      r_lfsr  <= SEED_EFF;
      r_cnt   <= '0;
      r_vld   <= 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          r_lfsr <= {r_lfsr[14:0], w_fb};
          r_cnt  <= r_cnt + 17'd1;
          if (r_cnt == RUN_END) begin
            r_vld   <= 1'b0;
            r_state <= (DUT_LAT > 0) ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt + 17'd1;
          if (r_cnt == FLUSH_END) r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Capture qualifier: pattern valid delayed by the netlist latency.
  generate
    if (DUT_LAT == 0) begin : g_nodly
      assign w_cap_vld = r_vld;
    end else begin : g_dly
      logic [DUT_LAT-1:0] r_dly;
      // Shift the valid bit along the latency line.
      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          r_dly <= '0;
        end else if (w_start) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= r_vld;
          for (int i = 1; i < DUT_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_cap_vld = r_dly[DUT_LAT-1];
    end
  endgenerate

  // Signature compaction, cleared at the start of every run.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN)            r_misr <= '0;
    else if (w_start)   r_misr <= '0;
    else if (w_cap_vld) r_misr <= w_misr_nxt;
  end

`ifdef NETLIST_BIST_COMPARE_EN
  logic        r_pass;
  logic        w_enter_done;
  logic [15:0] w_misr_final;

  // The last capture lands on the same edge that enters DONE, so compare
  // against the post-capture value rather than the current register.
  assign w_enter_done = ((r_state == S_RUN) && (r_cnt == RUN_END) && (DUT_LAT == 0)) ||
                        ((r_state == S_FLUSH) && (r_cnt == FLUSH_END));
  assign w_misr_final = w_cap_vld ? w_misr_nxt : r_misr;

  // Golden compare result, latched on DONE entry and cleared on restart.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN)               r_pass <= 1'b0;
    else if (w_start)      r_pass <= 1'b0;
    else if (w_enter_done) r_pass <= (w_misr_final == GOLDEN);
  end
  assign bus.pass_o = r_pass;
`else
  assign bus.pass_o = 1'b0;
`endif

  assign bus.pattern_o     = r_lfsr[PAT_W-1:0];
  assign bus.pattern_vld_o = r_vld;
  assign bus.busy_o        = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign bus.done_o        = (r_state == S_DONE);
  assign bus.signature_o   = r_misr;

endmodule

// File: tb/tb_netlist_bist.sv
// tb_netlist_bist: three harness instances run side by side.
//   A: DUT_LAT=3 with a 3-register echo netlist
//   B: DUT_LAT=0 with random responses
//   C: NUM_PAT=4, GOLDEN=0, combinational echo with optional bit-0 flip
module tb_netlist_bist;
  localparam int N  = 24;
  localparam int NC = 4;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start_ab = 1'b0;
  logic        start_c  = 1'b0;
  logic [15:0] resp_b   = '0;
  logic        flip_c   = 1'b0;
  logic [15:0] p1, p2, p3;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 CK = ~CK;

  netlist_bist_if #(.PAT_W(16), .RSP_W(16)) if_a ();
  netlist_bist_if #(.PAT_W(16), .RSP_W(16)) if_b ();
  netlist_bist_if #(.PAT_W(16), .RSP_W(16)) if_c ();

  assign if_a.start_i    = start_ab;
  assign if_b.start_i    = start_ab;
  assign if_c.start_i    = start_c;
  assign if_a.response_i = p3;
  assign if_b.response_i = resp_b;
  assign if_c.response_i = if_c.pattern_o ^ {15'd0, flip_c};

  // Three-stage registered echo netlist for instance A
  always @(posedge CK) begin
    p1 <= if_a.pattern_o;
    p2 <= p1;
    p3 <= p2;
  end

  netlist_bist #(.NUM_PAT(N), .DUT_LAT(3)) u_a (.CK(CK), .RN(RN), .bus(if_a));
  netlist_bist #(.NUM_PAT(N), .DUT_LAT(0)) u_b (.CK(CK), .RN(RN), .bus(if_b));
  netlist_bist #(.NUM_PAT(NC), .DUT_LAT(0), .GOLDEN(16'h0000)) u_c (.CK(CK), .RN(RN), .bus(if_c));

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] r);
    return (m << 1) ^ (m[15] ? 16'h6801 : 16'h0000) ^ r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One run on all instances; rst_k >= 0 aborts it with a reset pulse.
  task automatic run(input bit mid_start, input int flip_k, input int rst_k);
    logic [15:0] pat [N+4];
    logic [15:0] rsp [N];
    logic [15:0] sa, sb, sc;
    logic        exp_pass;
    pat[0] = 16'h0001;
    for (int k = 1; k < N + 4; k++) pat[k] = lfsr_step(pat[k-1]);
    for (int k = 0; k < N; k++) rsp[k] = 16'($urandom);
    sa = '0; sb = '0; sc = '0;
    for (int k = 0; k < N; k++) begin
      sa = misr_step(sa, pat[k]);
      sb = misr_step(sb, rsp[k]);
    end
    for (int k = 0; k < NC; k++) sc = misr_step(sc, pat[k] ^ ((k == flip_k) ? 16'h0001 : 16'h0000));
`ifdef NETLIST_BIST_COMPARE_EN
    exp_pass = (sc == 16'h0000);
`else
    exp_pass = 1'b0;
`endif
    @(negedge CK); start_ab = 1'b1; start_c = 1'b1;
    @(negedge CK); start_ab = 1'b0; start_c = 1'b0;
    for (int k = 0; k <= N + 3; k++) begin
      if (k == 0) begin
        chk("sig_b_clr", if_b.signature_o, 16'h0000);
        chk("sig_a_clr", if_a.signature_o, 16'h0000);
        chk("pass_c_clr", if_c.pass_o, 1'b0);
      end
      if (k < N) begin
        chk("pat_b", if_b.pattern_o, pat[k]);
        chk("vld_b", if_b.pattern_vld_o, 1'b1);
        chk("busy_b", if_b.busy_o, 1'b1);
        chk("pat_a", if_a.pattern_o, pat[k]);
        chk("vld_a", if_a.pattern_vld_o, 1'b1);
      end
      if (k == 11) begin
        logic [15:0] p11 = 16'h0801;
        chk("pat11", if_b.pattern_o, p11);
      end
      if (k == N) begin
        chk("done_b", if_b.done_o, 1'b1);
        chk("busy_b_end", if_b.busy_o, 1'b0);
        chk("sig_b", if_b.signature_o, sb);
      end
      if (k >= N && k < N + 3) begin
        chk("flush_busy_a", if_a.busy_o, 1'b1);
        chk("flush_vld_a", if_a.pattern_vld_o, 1'b0);
        chk("flush_done_a", if_a.done_o, 1'b0);
      end
      if (k == N + 3) begin
        chk("done_a", if_a.done_o, 1'b1);
        chk("sig_a", if_a.signature_o, sa);
      end
      if (k < NC) chk("pat_c", if_c.pattern_o, pat[k]);
      if (k == NC) begin
        chk("done_c", if_c.done_o, 1'b1);
        chk("sig_c", if_c.signature_o, sc);
        chk("pass_c", if_c.pass_o, exp_pass);
      end
      if (k == rst_k) begin
        #1 RN = 1'b0;
        #1;
        chk("rst_busy_b", if_b.busy_o, 1'b0);
        chk("rst_done_b", if_b.done_o, 1'b0);
        chk("rst_sig_b", if_b.signature_o, 16'h0000);
        chk("rst_pat_b", if_b.pattern_o, 16'h0001);
        chk("rst_vld_b", if_b.pattern_vld_o, 1'b0);
        chk("rst_busy_a", if_a.busy_o, 1'b0);
        chk("rst_sig_a", if_a.signature_o, 16'h0000);
        #1 RN = 1'b1;
        @(negedge CK);
        chk("post_rst_busy_b", if_b.busy_o, 1'b0);
        chk("post_rst_done_b", if_b.done_o, 1'b0);
        chk("post_rst_pat_b", if_b.pattern_o, 16'h0001);
        return;
      end
      resp_b   = (k < N) ? rsp[k] : 16'($urandom);
      flip_c   = (k == flip_k);
      start_ab = mid_start && (k == 5);
      @(negedge CK);
    end
    flip_c   = 1'b0;
    start_ab = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_busy", if_b.busy_o, 1'b0);
    chk("rst_done", if_b.done_o, 1'b0);
    chk("rst_vld", if_b.pattern_vld_o, 1'b0);
    chk("rst_sig", if_b.signature_o, 16'h0000);
    chk("rst_pat", if_b.pattern_o, 16'h0001);
    chk("rst_pass", if_c.pass_o, 1'b0);
    #1 RN = 1'b1;
    run(1'b1, -1, -1);
    run(1'b0, int'($urandom_range(0, NC - 1)), -1);
    run(1'b0, -1, 5);
    run(1'b1, int'($urandom_range(0, NC - 1)), -1);
    run(1'b0, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
